// File: rtl/dnd_dice_pkg.sv
// Shared encodings for the dice roller: die selection codes, per-die side counts and
// rejection limits, and the roll FSM state encoding.
package dnd_dice_pkg;

    localparam logic [2:0] DIE_D4   = 3'd0;
    localparam logic [2:0] DIE_D6   = 3'd1;
    localparam logic [2:0] DIE_D8   = 3'd2;
    localparam logic [2:0] DIE_D10  = 3'd3;
    localparam logic [2:0] DIE_D12  = 3'd4;
    localparam logic [2:0] DIE_D20  = 3'd5;
    localparam logic [2:0] DIE_D100 = 3'd6;
    localparam logic [2:0] DIE_D2   = 3'd7;

    // Indexed by die_sel
    localparam logic [6:0] SIDES [8] = '{7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd100, 7'd2};

    // Largest multiple of SIDES that fits in 0..256; 9 bits so 256 means "never reject"
    localparam logic [8:0] LIMIT [8] = '{9'd256, 9'd252, 9'd256, 9'd250,
                                         9'd252, 9'd240, 9'd200, 9'd256};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER_HI,
        ST_GATHER_LO,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dice_range_map.sv
// Maps an 8-bit raw draw onto a die face and decides whether the draw is unbiased
// enough to accept (or must be accepted anyway on the last try).
module dice_range_map
    import dnd_dice_pkg::*;
(
    input  logic [7:0] raw,
    input  logic [2:0] die_sel,
    input  logic       last_try,
    output logic       accept,
    output logic       biased,
    output logic [6:0] face
);

    logic       in_range;
    logic [6:0] rem;

    assign in_range = ({1'b0, raw} < LIMIT[die_sel]);
    assign accept   = in_range | last_try;
    // Only an out-of-range draw taken on the last try skews the distribution
    assign biased   = ~in_range & last_try;

    always_comb begin
        rem = '0;
        case (die_sel)
            DIE_D4:   rem = 7'(raw % 8'(SIDES[DIE_D4]));
            DIE_D6:   rem = 7'(raw % 8'(SIDES[DIE_D6]));
            DIE_D8:   rem = 7'(raw % 8'(SIDES[DIE_D8]));
            DIE_D10:  rem = 7'(raw % 8'(SIDES[DIE_D10]));
            DIE_D12:  rem = 7'(raw % 8'(SIDES[DIE_D12]));
            DIE_D20:  rem = 7'(raw % 8'(SIDES[DIE_D20]));
            DIE_D100: rem = 7'(raw % 8'(SIDES[DIE_D100]));
            default:  rem = 7'(raw % 8'(SIDES[DIE_D2]));
        endcase
    end

    assign face = rem + 7'd1;

endmodule

// File: rtl/dnd_dice_roller.sv
// Dice roller: builds 8-bit draws from the LFSR nibble stream, rejection-samples them
// into fair faces and sums up to MAX_DICE dice per request.
module dnd_dice_roller
    import dnd_dice_pkg::*;
#(
    parameter int MAX_DICE  = 4,
    parameter int MAX_TRIES = 4,
    parameter int SUM_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rnd_in,
    input  logic             rnd_valid,
    input  logic             roll_req,
    input  logic [2:0]       die_sel,
    input  logic [2:0]       num_dice,
    output logic             busy,
    output logic             result_valid,
    output logic [SUM_W-1:0] result_sum,
    output logic [6:0]       last_face,
    output logic             forced
);

    localparam int CNT_W = $clog2(MAX_DICE + 1);
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_t           state;
    logic [2:0]       sel;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] dice;
    logic [CNT_W-1:0] count_in;
    logic [TRY_W-1:0] tries;
    logic [7:0]       raw;

    logic             last_try;
    logic             accept;
    logic             biased;
    logic [6:0]       face;

    assign last_try = (tries == TRY_W'(MAX_TRIES - 1));

    // Zero dice still rolls one; oversize requests saturate at MAX_DICE
    always_comb begin
        count_in = CNT_W'(num_dice);
        if (num_dice == 3'd0)
            count_in = CNT_W'(1);
        else if (int'(num_dice) > MAX_DICE)
            count_in = CNT_W'(MAX_DICE);
    end

    dice_range_map u_map (
        .raw      (raw),
        .die_sel  (sel),
        .last_try (last_try),
        .accept   (accept),
        .biased   (biased),
        .face     (face)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel          <= '0;
            count        <= '0;
            dice         <= '0;
            tries        <= '0;
            raw          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_sum   <= '0;
            last_face    <= '0;
            forced       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (roll_req) begin
                        sel        <= die_sel;
                        count      <= count_in;
                        dice       <= '0;
                        tries      <= '0;
                        result_sum <= '0;
                        forced     <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_GATHER_HI;
                    end
                end
                ST_GATHER_HI: begin
                    if (rnd_valid) begin
                        raw[7:4] <= rnd_in;
                        state    <= ST_GATHER_LO;
                    end
                end
                ST_GATHER_LO: begin
                    if (rnd_valid) begin
                        raw[3:0] <= rnd_in;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        result_sum <= result_sum + SUM_W'(face);
                        last_face  <= face;
                        dice       <= dice + CNT_W'(1);
                        tries      <= '0;
                        forced     <= forced | biased;
                        if (dice + CNT_W'(1) == count) begin
                            result_valid <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            state <= ST_GATHER_HI;
                        end
                    end else begin
                        tries <= tries + TRY_W'(1);
                        state <= ST_GATHER_HI;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
